// File: rtl/vex_pkg.sv
// Shared definitions for the vector execute unit: opcodes, lane width,
// FSM state encoding and the vector-opcode decode helper.
package vex_pkg;

    localparam int unsigned LANE_W  = 8;
    localparam int unsigned LANES_D = 6;

    localparam logic [4:0] VADD = 5'h10;
    localparam logic [4:0] VSUB = 5'h11;
    localparam logic [4:0] VAND = 5'h12;
    localparam logic [4:0] VOR  = 5'h13;
    localparam logic [4:0] VXOR = 5'h14;
    localparam logic [4:0] VMUL = 5'h15;

    typedef enum logic {
        StIdle,
        StMul
    } vex_state_e;

    // Vector opcodes occupy the contiguous range VADD..VMUL.
    function automatic logic is_vector(input logic [4:0] op);
        return (op >= VADD) && (op <= VMUL);
    endfunction

endpackage

// File: rtl/vector_ex_unit_if.sv
// ID/EX -> vector unit -> EX/MEM bundle. The master modport is the pipeline
// side (drives the instruction), the slave modport is the vector unit.
interface vector_ex_unit_if #(
    parameter int unsigned LANES = 6
);
    localparam int unsigned VecW = LANES * 8;

    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [4:0]      alu_control;
    logic [4:0]      vd;
    logic            reg_write;
    logic [VecW-1:0] RD1V;
    logic [VecW-1:0] RD2V;
    logic            out_valid;
    logic [VecW-1:0] out_result;
    logic [4:0]      out_vd;
    logic            out_reg_write;

    modport master (
        output in_valid, flush, alu_control, vd, reg_write, RD1V, RD2V,
        input  in_ready, out_valid, out_result, out_vd, out_reg_write
    );

    modport slave (
        input  in_valid, flush, alu_control, vd, reg_write, RD1V, RD2V,
        output in_ready, out_valid, out_result, out_vd, out_reg_write
    );

endinterface

// File: rtl/vex_lane_alu.sv
// Combinational single 8-bit lane ALU. Define VEX_SATURATE_EN to clamp
// add/mul overflow to 8'hFF and sub underflow to 8'h00; otherwise all
// arithmetic wraps modulo 256.
module vex_lane_alu
    import vex_pkg::*;
(
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    input  logic [4:0]        i_op,
    output logic [LANE_W-1:0] o_res
);

`ifdef VEX_SATURATE_EN
    logic [LANE_W:0]     w_sum;
    logic [LANE_W:0]     w_diff;
    logic [2*LANE_W-1:0] w_prod;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_prod = {8'h00, i_a} * {8'h00, i_b};

    // Decode opcode; arithmetic results clamp on carry/borrow/high product bits.
    always_comb begin
        o_res = '0;
        case (i_op)
            VADD:    o_res = w_sum[LANE_W] ? 8'hFF : w_sum[LANE_W-1:0];
            VSUB:    o_res = w_diff[LANE_W] ? 8'h00 : w_diff[LANE_W-1:0];
            VAND:    o_res = i_a & i_b;
            VOR:     o_res = i_a | i_b;
            VXOR:    o_res = i_a ^ i_b;
            VMUL:    o_res = (|w_prod[2*LANE_W-1:LANE_W]) ? 8'hFF : w_prod[LANE_W-1:0];
            default: o_res = '0;
        endcase
    end
`else
    logic [LANE_W-1:0] w_sum;
    logic [LANE_W-1:0] w_diff;
    logic [LANE_W-1:0] w_prod;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_prod = i_a * i_b;

    // Decode opcode; arithmetic results wrap modulo 256.
    always_comb begin
        o_res = '0;
        case (i_op)
            VADD:    o_res = w_sum;
            VSUB:    o_res = w_diff;
            VAND:    o_res = i_a & i_b;
            VOR:     o_res = i_a | i_b;
            VXOR:    o_res = i_a ^ i_b;
            VMUL:    o_res = w_prod;
            default: o_res = '0;
        endcase
    end
`endif

endmodule

// File: rtl/vector_ex_unit.sv
// Execute-stage vector unit. Logic/add/sub ops run on all lanes in parallel
// and register in one cycle; VMUL runs one lane per cycle through a single
// shared lane ALU and stalls ID/EX via in_ready meanwhile.
// Optional build macro: VEX_SATURATE_EN (saturating lane arithmetic).
module vector_ex_unit
    import vex_pkg::*;
#(
    parameter int unsigned LANES = LANES_D
) (
    input logic             clk,
    input logic             rst,
    vector_ex_unit_if.slave bus
);

    localparam int unsigned VecW = LANES * LANE_W;
    localparam int unsigned CntW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CntW-1:0] LastLane = CntW'(LANES - 1);

    vex_state_e      r_state;
    vex_state_e      w_state_next;
    logic [CntW-1:0] r_lane_cnt;
    logic [CntW-1:0] w_cnt_next;

    logic [VecW-1:0] r_a;
    logic [VecW-1:0] r_b;
    logic [4:0]      r_vd;
    logic            r_reg_write;
    // Multiply lanes accumulate here so the visible result holds until done.
    logic [VecW-1:0] r_mul_acc;

    logic            r_out_valid;
    logic [VecW-1:0] r_result;
    logic [4:0]      r_out_vd;
    logic            r_out_reg_write;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_accept_mul;
    logic            w_par_done;
    logic            w_mul_done;
    logic [VecW-1:0] w_par_result;
    logic [LANE_W-1:0] w_mul_a;
    logic [LANE_W-1:0] w_mul_b;
    logic [LANE_W-1:0] w_mul_lane;
    logic [VecW-1:0] w_mul_merged;

    assign w_in_ready   = rst & (r_state == StIdle);
    assign w_accept     = rst & bus.in_valid & w_in_ready & ~bus.flush
                          & is_vector(bus.alu_control);
    assign w_accept_mul = w_accept & (bus.alu_control == VMUL);

    // Parallel lane ALUs for the single-cycle ops, fed straight from ID/EX.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        vex_lane_alu u_lane_alu (
            .i_a   (bus.RD1V[g*LANE_W +: LANE_W]),
            .i_b   (bus.RD2V[g*LANE_W +: LANE_W]),
            .i_op  (bus.alu_control),
            .o_res (w_par_result[g*LANE_W +: LANE_W])
        );
    end

    assign w_mul_a = r_a[r_lane_cnt*LANE_W +: LANE_W];
    assign w_mul_b = r_b[r_lane_cnt*LANE_W +: LANE_W];

    // Shared lane ALU stepping through captured operands for VMUL.
    vex_lane_alu u_mul_alu (
        .i_a   (w_mul_a),
        .i_b   (w_mul_b),
        .i_op  (VMUL),
        .o_res (w_mul_lane)
    );

    // Insert the current multiply lane into the accumulated vector.
    always_comb begin
        w_mul_merged = r_mul_acc;
        w_mul_merged[r_lane_cnt*LANE_W +: LANE_W] = w_mul_lane;
    end

    // FSM next state, lane counter and completion strobes.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_lane_cnt;
        w_par_done   = 1'b0;
        w_mul_done   = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_accept_mul) begin
                    w_state_next = StMul;
                    w_cnt_next   = '0;
                end else if (w_accept) begin
                    w_par_done = 1'b1;
                end
            end
            StMul: begin
                if (bus.flush) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end else if (r_lane_cnt == LastLane) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                    w_mul_done   = 1'b1;
                end else begin
                    w_cnt_next = r_lane_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = '0;
            end
        endcase
    end

    // FSM state and lane counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_lane_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lane_cnt <= w_cnt_next;
        end
    end

    // Operand capture, multiply accumulation and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a             <= '0;
            r_b             <= '0;
            r_vd            <= '0;
            r_reg_write     <= 1'b0;
            r_mul_acc       <= '0;
            r_out_valid     <= 1'b0;
            r_result        <= '0;
            r_out_vd        <= '0;
            r_out_reg_write <= 1'b0;
        end else begin
            r_out_valid <= w_par_done | w_mul_done;
            if (w_accept_mul) begin
                r_a         <= bus.RD1V;
                r_b         <= bus.RD2V;
                r_vd        <= bus.vd;
                r_reg_write <= bus.reg_write;
                r_mul_acc   <= '0;
            end else if (r_state == StMul) begin
                r_mul_acc <= w_mul_merged;
            end
            if (w_par_done) begin
                r_result        <= w_par_result;
                r_out_vd        <= bus.vd;
                r_out_reg_write <= bus.reg_write;
            end else if (w_mul_done) begin
                r_result        <= w_mul_merged;
                r_out_vd        <= r_vd;
                r_out_reg_write <= r_reg_write;
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_result    = r_result;
    assign bus.out_vd        = r_out_vd;
    assign bus.out_reg_write = r_out_reg_write;

endmodule

// File: doc/vector_ex_unit.md
# vector_ex_unit

Execute-stage vector unit sitting directly downstream of the ID/EX pipeline register. Consumes the 48-bit vector operands, vector destination and ALU control from ID/EX and produces a registered vector result for the EX/MEM register. Single-cycle lane-parallel logic ops plus a lane-serial 6-cycle multiply; back-pressures ID/EX through `in_ready` while a multiply is in flight.

## Interface
- `LANES`, 6, number of 8-bit lanes; vector width = `LANES*8` (48)
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset
- `in_valid`  in  1  ID/EX holds a valid instruction
- `in_ready`  out  1  unit can accept this cycle; hazard unit stalls IF/ID/ID-EX when low
- `flush`  in  1  kill in-flight op and drop any input this cycle
- `alu_control`  in  5  operation code from ID/EX
- `vd`  in  5  vector destination register
- `reg_write`  in  1  write-enable from ID/EX
- `RD1V`, `RD2V`  in  48  vector operands; lane i = bits [8i+7:8i]
- `out_valid`  out  1  result valid, one cycle per accepted op
- `out_result`  out  48  vector result
- `out_vd`  out  5  captured `vd`
- `out_reg_write`  out  1  captured `reg_write`, qualified by `out_valid`

## Operation
- Vector opcodes: VADD 5'h10, VSUB 5'h11, VAND 5'h12, VOR 5'h13, VXOR 5'h14, VMUL 5'h15. Any other code is non-vector: ignored, no output, no state change.
- Accept = `rst & in_valid & in_ready & !flush & is_vector(alu_control)`; operands, `vd`, `reg_write`, op captured on accept.
- FSM: IDLE, MUL.
  - IDLE, accept of non-MUL op: per-lane result registered; `out_valid`=1 next cycle; stay IDLE.
  - IDLE, accept of VMUL: go MUL, `lane_cnt`=0.
  - MUL: each cycle compute lane `lane_cnt` (8x8 unsigned, low 8 bits) into result register, increment; at `lane_cnt`=LANES-1 write last lane, go IDLE, `out_valid`=1.
  - MUL, `flush`=1: go IDLE, `lane_cnt`=0, no `out_valid`; partial result discarded.
- `in_ready` = `rst & (state==IDLE)`; combinational, no dependency on `in_valid`.
- Lane arithmetic unsigned 8-bit, independent lanes, no carries across lanes; wrap-around by default.
- `out_valid` is a one-cycle pulse; `out_result`/`out_vd`/`out_reg_write` hold last values when `out_valid`=0.
- `flush` has priority over accept; flush in IDLE only suppresses the same-cycle accept.

## Timing
- Reset (rst=0 at edge): state IDLE, `lane_cnt`=0, `out_valid`=0, `out_result`=0, `out_vd`=0, `out_reg_write`=0; `in_ready`=0 while rst low. Reset mid-multiply aborts with no output.
- Single-cycle ops: accept at edge E0, `out_valid` high after E0 for one cycle; back-to-back accepts every cycle.
- VMUL: accept at E0; lanes 0..5 written at E1..E6; `out_valid` high after E6; `in_ready` low after E0 through E6; next accept earliest at E7.
- Simultaneous last-lane and `flush`: flush wins, no `out_valid`.

## Configuration
- `VEX_SATURATE_EN` defined: VADD/VMUL clamp each lane to 8'hFF on overflow, VSUB clamps to 8'h00 on underflow; logic ops unaffected.
- Undefined: all lanes wrap modulo 256; no clamp logic compiled.

## Structure
- Shared package `vex_pkg`: opcode localparams (VADD..VMUL), `is_vector` function, lane width constant (8), FSM state enum.
- One sub-module `vex_lane_alu`: combinational single-lane 8-bit ALU (add/sub/and/or/xor/mul, saturation under the macro); instantiated LANES times for parallel ops, one extra instance muxed by `lane_cnt` for VMUL.

## Test plan
- Reset: hold rst=0 two cycles with in_valid=1 -> all outputs 0, `in_ready`=0, no `out_valid`; release -> `in_ready`=1.
- VADD RD1V=48'h0102030405FF, RD2V=48'h010101010101, vd=3 -> next cycle `out_valid`=1, `out_result`=48'h020304050600 (48'h0203040506FF with `VEX_SATURATE_EN`), `out_vd`=3.
- VSUB RD1V=48'h000000000010, RD2V=48'h000000000001 back-to-back with VXOR 48'hFF00FF00FF00^48'h0F0F0F0F0F0F -> 48'hFFFFFFFFFF0F then 48'hF00FF00FF00F on consecutive cycles (sat: lanes 5..1 = 00).
- VMUL RD1V=48'h020304050607, RD2V=48'h030303030303 -> `in_ready` low 6 cycles, `out_valid` exactly 6 cycles after accept, result 48'h06090C0F1215; RD1V lane0=8'h10, RD2V lane0=8'h11 -> lane0 8'h10 (8'hFF saturating).
- VMUL then `flush` at cycle 3 -> no `out_valid`, `in_ready`=1 next cycle, following VAND accepted normally.
- in_valid=1 with alu_control=5'h02 (scalar) -> no `out_valid`, outputs unchanged, `in_ready` stays 1.
